// File: rtl/sram_rr_arbiter_2p_if.sv
// Client request/response channels for ports A and B plus the SRAM macro port-0 pins.
// The slave modport is the arbiter's view; the master modport is the clients-plus-macro side.
interface sram_rr_arbiter_2p_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  a_req_valid;
    logic                  a_req_ready;
    logic                  a_req_we;
    logic [ADDR_WIDTH-1:0] a_req_addr;
    logic [DATA_WIDTH-1:0] a_req_wdata;
    logic                  a_rsp_valid;
    logic [DATA_WIDTH-1:0] a_rsp_rdata;

    logic                  b_req_valid;
    logic                  b_req_ready;
    logic                  b_req_we;
    logic [ADDR_WIDTH-1:0] b_req_addr;
    logic [DATA_WIDTH-1:0] b_req_wdata;
    logic                  b_rsp_valid;
    logic [DATA_WIDTH-1:0] b_rsp_rdata;

    logic                  sram_csb;
    logic                  sram_web;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_din;
    logic [DATA_WIDTH-1:0] sram_dout;

    modport slave (
        input  a_req_valid, a_req_we, a_req_addr, a_req_wdata,
        output a_req_ready, a_rsp_valid, a_rsp_rdata,
        input  b_req_valid, b_req_we, b_req_addr, b_req_wdata,
        output b_req_ready, b_rsp_valid, b_rsp_rdata,
        output sram_csb, sram_web, sram_addr, sram_din,
        input  sram_dout
    );

    modport master (
        output a_req_valid, a_req_we, a_req_addr, a_req_wdata,
        input  a_req_ready, a_rsp_valid, a_rsp_rdata,
        output b_req_valid, b_req_we, b_req_addr, b_req_wdata,
        input  b_req_ready, b_rsp_valid, b_rsp_rdata,
        input  sram_csb, sram_web, sram_addr, sram_din,
        output sram_dout
    );
endinterface

// File: rtl/sram_rr_arbiter_2p.sv
// Two-port round-robin arbiter/sequencer driving port 0 of the 32x512 1RW SRAM macro.
// Read data returns to the issuing port two cycles after accept.
module sram_rr_arbiter_2p #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                   clk0,
    input  logic                   rst0_n,
    sram_rr_arbiter_2p_if.slave    bus
);
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic                  prio_r;
    logic                  grant_a_s;
    logic                  grant_b_s;
    logic                  grant_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;

    logic                  csb_r;
    logic                  web_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] din_r;

    logic                  s1_rd_r;
    logic                  s1_port_r;
    logic                  s2_rd_r;
    logic                  s2_port_r;

    logic                  a_rsp_valid_r;
    logic                  b_rsp_valid_r;
    logic [DATA_WIDTH-1:0] a_rsp_rdata_r;
    logic [DATA_WIDTH-1:0] b_rsp_rdata_r;

    // Grant selection: a lone requester wins, a tie goes to the priority holder.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (bus.a_req_valid && bus.b_req_valid) begin
            if (prio_r == PORT_A) begin
                grant_a_s = 1'b1;
            end else begin
                grant_b_s = 1'b1;
            end
        end else if (bus.a_req_valid) begin
            grant_a_s = 1'b1;
        end else if (bus.b_req_valid) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Request mux towards the command register.
    always_comb begin
        sel_we_s    = bus.a_req_we;
        sel_addr_s  = bus.a_req_addr;
        sel_wdata_s = bus.a_req_wdata;
        if (grant_b_s) begin
            sel_we_s    = bus.b_req_we;
            sel_addr_s  = bus.b_req_addr;
            sel_wdata_s = bus.b_req_wdata;
        end else begin
            sel_we_s    = bus.a_req_we;
            sel_addr_s  = bus.a_req_addr;
            sel_wdata_s = bus.a_req_wdata;
        end
    end

    assign grant_s         = grant_a_s | grant_b_s;
    assign bus.a_req_ready = grant_a_s;
    assign bus.b_req_ready = grant_b_s;

    // Priority pointer hands over to the loser after every grant.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            prio_r <= PORT_A;
        end else if (grant_a_s) begin
            prio_r <= PORT_B;
        end else if (grant_b_s) begin
            prio_r <= PORT_A;
        end else begin
            prio_r <= prio_r;
        end
    end

    // Command register feeding the macro pins; address/data hold when idle.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            csb_r  <= 1'b1;
            web_r  <= 1'b1;
            addr_r <= {ADDR_WIDTH{1'b0}};
            din_r  <= {DATA_WIDTH{1'b0}};
        end else if (grant_s) begin
            csb_r  <= 1'b0;
            web_r  <= ~sel_we_s;
            addr_r <= sel_addr_s;
            din_r  <= sel_wdata_s;
        end else begin
            csb_r  <= 1'b1;
            web_r  <= 1'b1;
        end
    end

    // Read tracking shift; stage 2 marks the edge where dout is valid.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            s1_rd_r   <= 1'b0;
            s1_port_r <= PORT_A;
            s2_rd_r   <= 1'b0;
            s2_port_r <= PORT_A;
        end else begin
            s1_rd_r   <= grant_s & ~sel_we_s;
            s1_port_r <= grant_b_s;
            s2_rd_r   <= s1_rd_r;
            s2_port_r <= s1_port_r;
        end
    end

    // Response capture for port A.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            a_rsp_valid_r <= 1'b0;
            a_rsp_rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (s2_rd_r && (s2_port_r == PORT_A)) begin
            a_rsp_valid_r <= 1'b1;
            a_rsp_rdata_r <= bus.sram_dout;
        end else begin
            a_rsp_valid_r <= 1'b0;
        end
    end

    // Response capture for port B.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            b_rsp_valid_r <= 1'b0;
            b_rsp_rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (s2_rd_r && (s2_port_r == PORT_B)) begin
            b_rsp_valid_r <= 1'b1;
            b_rsp_rdata_r <= bus.sram_dout;
        end else begin
            b_rsp_valid_r <= 1'b0;
        end
    end

    assign bus.sram_csb    = csb_r;
    assign bus.sram_web    = web_r;
    assign bus.sram_addr   = addr_r;
    assign bus.sram_din    = din_r;
    assign bus.a_rsp_valid = a_rsp_valid_r;
    assign bus.a_rsp_rdata = a_rsp_rdata_r;
    assign bus.b_rsp_valid = b_rsp_valid_r;
    assign bus.b_rsp_rdata = b_rsp_rdata_r;
endmodule

// File: tb/tb_sram_rr_arbiter_2p.sv
// Directed bench for sram_rr_arbiter_2p with a behavioural model of the 1RW SRAM macro.
module tb_sram_rr_arbiter_2p;
    logic clk0 = 1'b0;
    logic rst0_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    sram_rr_arbiter_2p_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) bus ();

    sram_rr_arbiter_2p #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
        .clk0   (clk0),
        .rst0_n (rst0_n),
        .bus    (bus)
    );

    always #5 clk0 = ~clk0;

    // Macro model: command sampled at posedge, write/read performed at the following negedge.
    logic [31:0] mem [0:511];
    logic        cmd_csb = 1'b1;
    logic        cmd_web = 1'b1;
    logic [8:0]  cmd_addr = 9'd0;
    logic [31:0] cmd_din = 32'd0;

    always @(posedge clk0) begin
        cmd_csb  <= bus.sram_csb;
        cmd_web  <= bus.sram_web;
        cmd_addr <= bus.sram_addr;
        cmd_din  <= bus.sram_din;
    end

    always @(negedge clk0) begin
        if (!cmd_csb && !cmd_web) begin
            mem[cmd_addr] = cmd_din;
            bus.sram_dout = 32'hxxxx_xxxx;
        end else if (!cmd_csb) begin
            bus.sram_dout = mem[cmd_addr];
        end else begin
            bus.sram_dout = 32'hxxxx_xxxx;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle();
        bus.a_req_valid = 1'b0;
        bus.a_req_we    = 1'b0;
        bus.a_req_addr  = 9'd0;
        bus.a_req_wdata = 32'd0;
        bus.b_req_valid = 1'b0;
        bus.b_req_we    = 1'b0;
        bus.b_req_addr  = 9'd0;
        bus.b_req_wdata = 32'd0;
    endtask

    task automatic do_reset();
        idle();
        rst0_n = 1'b0;
        tick();
        tick();
        rst0_n = 1'b1;
        #1;
    endtask

    initial begin
        idle();
        bus.sram_dout = 32'd0;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;

        // 1. Reset values
        rst0_n = 1'b0;
        tick();
        tick();
        check("rst_csb", {63'd0, bus.sram_csb}, 64'd1);
        check("rst_web", {63'd0, bus.sram_web}, 64'd1);
        check("rst_addr", {55'd0, bus.sram_addr}, 64'd0);
        check("rst_din", {32'd0, bus.sram_din}, 64'd0);
        check("rst_a_vld", {63'd0, bus.a_rsp_valid}, 64'd0);
        check("rst_b_vld", {63'd0, bus.b_rsp_valid}, 64'd0);
        check("rst_a_data", {32'd0, bus.a_rsp_rdata}, 64'd0);
        rst0_n = 1'b1;
        tick();
        check("idle_csb", {63'd0, bus.sram_csb}, 64'd1);
        check("idle_a_rdy", {63'd0, bus.a_req_ready}, 64'd0);
        bus.a_req_valid = 1'b1;
        bus.b_req_valid = 1'b1;
        #1;
        check("rst_prio_a", {63'd0, bus.a_req_ready}, 64'd1);
        check("rst_prio_b", {63'd0, bus.b_req_ready}, 64'd0);
        idle();
        #1;

        // 2. Write then read, port A
        bus.a_req_valid = 1'b1;
        bus.a_req_we    = 1'b1;
        bus.a_req_addr  = 9'h1FF;
        bus.a_req_wdata = 32'hDEADBEEF;
        #1;
        check("wr_a_rdy", {63'd0, bus.a_req_ready}, 64'd1);
        tick();
        check("wr_csb", {63'd0, bus.sram_csb}, 64'd0);
        check("wr_web", {63'd0, bus.sram_web}, 64'd0);
        check("wr_addr", {55'd0, bus.sram_addr}, 64'h1FF);
        check("wr_din", {32'd0, bus.sram_din}, 64'hDEADBEEF);
        bus.a_req_we    = 1'b0;
        bus.a_req_wdata = 32'd0;
        tick();
        check("rd_web", {63'd0, bus.sram_web}, 64'd1);
        idle();
        tick();
        check("rd_a_vld_t1", {63'd0, bus.a_rsp_valid}, 64'd0);
        tick();
        check("rd_a_vld_t2", {63'd0, bus.a_rsp_valid}, 64'd1);
        check("rd_a_data", {32'd0, bus.a_rsp_rdata}, 64'hDEADBEEF);
        check("rd_b_vld", {63'd0, bus.b_rsp_valid}, 64'd0);
        tick();
        check("rd_a_pulse", {63'd0, bus.a_rsp_valid}, 64'd0);
        check("rd_idle_csb", {63'd0, bus.sram_csb}, 64'd1);

        // 3. Contention after a fresh reset
        do_reset();
        mem[9'h010] = 32'h11111111;
        mem[9'h020] = 32'h22222222;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                bus.a_req_valid = 1'b1;
                bus.a_req_addr  = 9'h010;
                bus.b_req_valid = 1'b1;
                bus.b_req_addr  = 9'h020;
                #1;
                check($sformatf("cont_a_rdy%0d", k), {63'd0, bus.a_req_ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
                check($sformatf("cont_b_rdy%0d", k), {63'd0, bus.b_req_ready}, (k % 2 == 1) ? 64'd1 : 64'd0);
            end else begin
                idle();
            end
            tick();
            if (k >= 2) begin
                check($sformatf("cont_a_vld%0d", k), {63'd0, bus.a_rsp_valid}, (k % 2 == 0) ? 64'd1 : 64'd0);
                check($sformatf("cont_b_vld%0d", k), {63'd0, bus.b_rsp_valid}, (k % 2 == 1) ? 64'd1 : 64'd0);
                if (k % 2 == 0) check($sformatf("cont_a_dat%0d", k), {32'd0, bus.a_rsp_rdata}, 64'h11111111);
                else            check($sformatf("cont_b_dat%0d", k), {32'd0, bus.b_rsp_rdata}, 64'h22222222);
            end else begin
                check($sformatf("cont_none%0d", k), {62'd0, bus.a_rsp_valid, bus.b_rsp_valid}, 64'd0);
            end
        end

        // 4. Port B streaming reads
        for (int i = 0; i < 8; i++) mem[i] = i * 3;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                bus.b_req_valid = 1'b1;
                bus.b_req_we    = 1'b0;
                bus.b_req_addr  = k[8:0];
                #1;
                check($sformatf("strm_rdy%0d", k), {62'd0, bus.a_req_ready, bus.b_req_ready}, 64'd1);
            end else begin
                idle();
            end
            tick();
            if (k >= 2) begin
                check($sformatf("strm_vld%0d", k), {63'd0, bus.b_rsp_valid}, 64'd1);
                check($sformatf("strm_dat%0d", k), {32'd0, bus.b_rsp_rdata}, 64'((k - 2) * 3));
            end else begin
                check($sformatf("strm_vld%0d", k), {63'd0, bus.b_rsp_valid}, 64'd0);
            end
            check($sformatf("strm_a_vld%0d", k), {63'd0, bus.a_rsp_valid}, 64'd0);
        end
        tick();
        check("strm_b_end", {63'd0, bus.b_rsp_valid}, 64'd0);
        check("strm_a_hold", {32'd0, bus.a_rsp_rdata}, 64'h11111111);

        // 5. Reset while reads are in flight
        bus.a_req_valid = 1'b1;
        bus.a_req_addr  = 9'h010;
        #1;
        check("mid_a_rdy", {63'd0, bus.a_req_ready}, 64'd1);
        tick();
        tick();
        check("mid_csb_busy", {63'd0, bus.sram_csb}, 64'd0);
        idle();
        rst0_n = 1'b0;
        #1;
        check("mid_csb_rst", {63'd0, bus.sram_csb}, 64'd1);
        check("mid_a_vld_rst", {63'd0, bus.a_rsp_valid}, 64'd0);
        tick();
        rst0_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("mid_a_vld%0d", k), {63'd0, bus.a_rsp_valid}, 64'd0);
        end
        check("mid_a_data", {32'd0, bus.a_rsp_rdata}, 64'd0);
        bus.a_req_valid = 1'b1;
        bus.b_req_valid = 1'b1;
        #1;
        check("mid_prio_a", {62'd0, bus.a_req_ready, bus.b_req_ready}, 64'd2);
        idle();
        #1;

        // 6. Read then write to the same address
        mem[9'h100] = 32'hAAAAAAAA;
        bus.a_req_valid = 1'b1;
        bus.a_req_addr  = 9'h100;
        #1;
        check("war_a_rdy", {63'd0, bus.a_req_ready}, 64'd1);
        tick();
        idle();
        bus.b_req_valid = 1'b1;
        bus.b_req_we    = 1'b1;
        bus.b_req_addr  = 9'h100;
        bus.b_req_wdata = 32'h55555555;
        #1;
        check("war_b_rdy", {63'd0, bus.b_req_ready}, 64'd1);
        tick();
        idle();
        tick();
        check("war_a_vld", {63'd0, bus.a_rsp_valid}, 64'd1);
        check("war_a_old", {32'd0, bus.a_rsp_rdata}, 64'hAAAAAAAA);
        bus.a_req_valid = 1'b1;
        bus.a_req_addr  = 9'h100;
        tick();
        idle();
        check("war_b_nrsp", {63'd0, bus.b_rsp_valid}, 64'd0);
        tick();
        tick();
        check("war_a_vld2", {63'd0, bus.a_rsp_valid}, 64'd1);
        check("war_a_new", {32'd0, bus.a_rsp_rdata}, 64'h55555555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
